// File: rtl/proc_control_seq_pkg.sv
// Shared definitions for the multi-cycle control sequencer: widths, opcodes,
// ALU operation codes, FSM states, instruction classes and the decoded
// instruction record passed from the decoder to the sequencer.
package proc_control_seq_pkg;

  localparam int unsigned XLEN  = 16;
  localparam int unsigned RA_W  = 3;
  localparam int unsigned OP_W  = 4;
  localparam int unsigned RET_W = 32;

  localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OP_W-1:0] OP_ADD  = 4'h1;
  localparam logic [OP_W-1:0] OP_SUB  = 4'h2;
  localparam logic [OP_W-1:0] OP_AND  = 4'h3;
  localparam logic [OP_W-1:0] OP_OR   = 4'h4;
  localparam logic [OP_W-1:0] OP_XOR  = 4'h5;
  localparam logic [OP_W-1:0] OP_ADDI = 4'h6;
  localparam logic [OP_W-1:0] OP_LD   = 4'h7;
  localparam logic [OP_W-1:0] OP_ST   = 4'h8;
  localparam logic [OP_W-1:0] OP_BEQ  = 4'h9;
  localparam logic [OP_W-1:0] OP_JMP  = 4'hA;
  localparam logic [OP_W-1:0] OP_HALT = 4'hF;

  localparam logic [OP_W-1:0] ALU_ADD = 4'h1;
  localparam logic [OP_W-1:0] ALU_SUB = 4'h2;
  localparam logic [OP_W-1:0] ALU_AND = 4'h3;
  localparam logic [OP_W-1:0] ALU_OR  = 4'h4;
  localparam logic [OP_W-1:0] ALU_XOR = 4'h5;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALT
  } state_e;

  // CL_NOP must stay the zero encoding so a cleared record decodes as NOP.
  typedef enum logic [2:0] {
    CL_NOP, CL_ALU, CL_LD, CL_ST, CL_BEQ, CL_JMP, CL_HALT, CL_ILL
  } cls_e;

  typedef struct packed {
    cls_e                cls;
    logic [RA_W-1:0]     ra1;
    logic [RA_W-1:0]     ra2;
    logic [RA_W-1:0]     wa;
    logic [XLEN-1:0]     imm;
    logic [OP_W-1:0]     alu_op;
    logic                alu_src_imm;
  } dec_t;

  function automatic logic [XLEN-1:0] sext6(input logic [5:0] v);
    return {{(XLEN-6){v[5]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] sext12(input logic [11:0] v);
    return {{(XLEN-12){v[11]}}, v};
  endfunction

endpackage

// File: rtl/proc_control_seq_if.sv
// Bus between the control sequencer and its memories / regfile+ALU datapath.
// master: sequencer side (drives requests, pc/ir, regfile and ALU controls).
// slave : memory/datapath side (drives acks, instruction word, alu_zero).
interface proc_control_seq_if;
  import proc_control_seq_pkg::*;

  logic              imem_req;
  logic [XLEN-1:0]   imem_addr;
  logic              imem_ack;
  logic [XLEN-1:0]   instr;
  logic              dmem_req;
  logic              dmem_we;
  logic              dmem_ack;
  logic              alu_zero;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   ir;
  logic [RA_W-1:0]   read_addr1;
  logic [RA_W-1:0]   read_addr2;
  logic [RA_W-1:0]   write_addr;
  logic              write_enable;
  logic [OP_W-1:0]   alu_op;
  logic              alu_src_imm;
  logic [XLEN-1:0]   imm;
  logic              wb_sel;
  logic              halted;
  logic              fault;
  logic [RET_W-1:0]  retired;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, pc, ir,
           read_addr1, read_addr2, write_addr, write_enable,
           alu_op, alu_src_imm, imm, wb_sel, halted, fault, retired,
    input  imem_ack, instr, dmem_ack, alu_zero
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, pc, ir,
           read_addr1, read_addr2, write_addr, write_enable,
           alu_op, alu_src_imm, imm, wb_sel, halted, fault, retired,
    output imem_ack, instr, dmem_ack, alu_zero
  );

endinterface

// File: rtl/proc_control_seq_decode.sv
// Combinational instruction decoder.
// Ports: instr_i - raw 16-bit instruction word
//        dec_o   - regfile addresses, sign-extended immediate, ALU controls,
//                  instruction class (CL_ILL for opcodes B-E)
module proc_control_seq_decode
  import proc_control_seq_pkg::*;
(
  input  logic [XLEN-1:0] instr_i,
  output dec_t            dec_o
);

  logic [OP_W-1:0] op_c;
  assign op_c = instr_i[15:12];

  always_comb begin
    dec_o             = '0;
    dec_o.cls         = CL_NOP;
    dec_o.ra1         = instr_i[8:6];
    dec_o.ra2         = instr_i[5:3];
    dec_o.wa          = instr_i[11:9];
    dec_o.imm         = sext6(instr_i[5:0]);
    dec_o.alu_op      = ALU_ADD;
    dec_o.alu_src_imm = 1'b0;
    case (op_c)
      OP_NOP:  dec_o.cls = CL_NOP;
      OP_ADD:  begin dec_o.cls = CL_ALU; dec_o.alu_op = ALU_ADD; end
      OP_SUB:  begin dec_o.cls = CL_ALU; dec_o.alu_op = ALU_SUB; end
      OP_AND:  begin dec_o.cls = CL_ALU; dec_o.alu_op = ALU_AND; end
      OP_OR:   begin dec_o.cls = CL_ALU; dec_o.alu_op = ALU_OR;  end
      OP_XOR:  begin dec_o.cls = CL_ALU; dec_o.alu_op = ALU_XOR; end
      OP_ADDI: begin dec_o.cls = CL_ALU; dec_o.alu_src_imm = 1'b1; end
      OP_LD:   begin dec_o.cls = CL_LD;  dec_o.alu_src_imm = 1'b1; end
      // Store data register sits in the rd field; route it to port 2.
      OP_ST:   begin dec_o.cls = CL_ST;  dec_o.alu_src_imm = 1'b1; dec_o.ra2 = instr_i[11:9]; end
      // BEQ compares ra/rb by subtraction; alu_zero reports equality.
      OP_BEQ:  begin
        dec_o.cls    = CL_BEQ;
        dec_o.alu_op = ALU_SUB;
        dec_o.ra1    = instr_i[11:9];
        dec_o.ra2    = instr_i[8:6];
      end
      OP_JMP:  begin dec_o.cls = CL_JMP; dec_o.imm = sext12(instr_i[11:0]); end
      OP_HALT: dec_o.cls = CL_HALT;
      default: dec_o.cls = CL_ILL;
    endcase
  end

endmodule

// File: rtl/proc_control_seq.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB control sequencer for the 16-bit core.
// Owns pc, ir and the retired counter; all bus outputs are registered.
// Ports: clk   - clock, all logic on posedge
//        reset - synchronous, active-low
//        bus   - master side of proc_control_seq_if (memories + regfile/ALU)
module proc_control_seq
  import proc_control_seq_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC    = 16'h0000,
  // Consecutive unacknowledged request cycles before fault-halt; 0 disables.
  parameter int unsigned     MEM_TIMEOUT = 255
)(
  input  logic                    clk,
  input  logic                    reset,
  proc_control_seq_if.master      bus
);

  localparam int unsigned TO_W = 16;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   ir_q, ir_d;
  dec_t              dec_q, dec_d, dec_c;
  logic [RET_W-1:0]  retired_q, retired_d;
  logic              fault_q, fault_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              imem_req_q, dmem_req_q, dmem_we_q;
  logic              write_enable_q, wb_sel_q, halted_q;
  logic              to_hit_c;
  logic [XLEN-1:0]   pc_inc_c;

  proc_control_seq_decode u_decode (
    .instr_i (bus.instr),
    .dec_o   (dec_c)
  );

  assign pc_inc_c = pc_q + XLEN'(1);
  assign to_hit_c = (MEM_TIMEOUT != 0) && ((to_cnt_q + TO_W'(1)) == TO_W'(MEM_TIMEOUT));

  // Next-state logic; acks only count while our own request is registered high.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    dec_d     = dec_q;
    retired_d = retired_q;
    fault_d   = fault_q;
    to_cnt_d  = to_cnt_q;
    unique case (state_q)
      S_FETCH: begin
        if (imem_req_q) begin
          if (bus.imem_ack) begin
            ir_d     = bus.instr;
            dec_d    = dec_c;
            to_cnt_d = '0;
            state_d  = S_DECODE;
          end else if (to_hit_c) begin
            fault_d  = 1'b1;
            to_cnt_d = '0;
            state_d  = S_HALT;
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end
      end
      S_DECODE: begin
        case (dec_q.cls)
          CL_NOP:  begin pc_d = pc_inc_c; retired_d = retired_q + RET_W'(1); state_d = S_FETCH; end
          CL_HALT: begin retired_d = retired_q + RET_W'(1); state_d = S_HALT; end
          CL_ILL:  begin fault_d = 1'b1; state_d = S_HALT; end
          default: state_d = S_EXECUTE;
        endcase
      end
      S_EXECUTE: begin
        case (dec_q.cls)
          CL_ALU:         state_d = S_WB;
          CL_LD, CL_ST:   state_d = S_MEM;
          CL_BEQ: begin
            pc_d      = pc_inc_c + (bus.alu_zero ? dec_q.imm : XLEN'(0));
            retired_d = retired_q + RET_W'(1);
            state_d   = S_FETCH;
          end
          CL_JMP: begin
            pc_d      = pc_inc_c + dec_q.imm;
            retired_d = retired_q + RET_W'(1);
            state_d   = S_FETCH;
          end
          default: begin fault_d = 1'b1; state_d = S_HALT; end
        endcase
      end
      S_MEM: begin
        if (bus.dmem_ack) begin
          to_cnt_d = '0;
          if (dec_q.cls == CL_ST) begin
            pc_d      = pc_inc_c;
            retired_d = retired_q + RET_W'(1);
            state_d   = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (to_hit_c) begin
          fault_d  = 1'b1;
          to_cnt_d = '0;
          state_d  = S_HALT;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      S_WB: begin
        pc_d      = pc_inc_c;
        retired_d = retired_q + RET_W'(1);
        state_d   = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  // State and output registers; strobes are decoded from the next state so
  // they are valid for exactly the cycles spent in the matching state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= S_FETCH;
      pc_q           <= RESET_PC;
      ir_q           <= '0;
      dec_q          <= '0;
      retired_q      <= '0;
      fault_q        <= 1'b0;
      to_cnt_q       <= '0;
      imem_req_q     <= 1'b0;
      dmem_req_q     <= 1'b0;
      dmem_we_q      <= 1'b0;
      write_enable_q <= 1'b0;
      wb_sel_q       <= 1'b0;
      halted_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      ir_q           <= ir_d;
      dec_q          <= dec_d;
      retired_q      <= retired_d;
      fault_q        <= fault_d;
      to_cnt_q       <= to_cnt_d;
      imem_req_q     <= (state_d == S_FETCH);
      dmem_req_q     <= (state_d == S_MEM);
      dmem_we_q      <= (state_d == S_MEM) && (dec_d.cls == CL_ST);
      write_enable_q <= (state_d == S_WB);
      wb_sel_q       <= (state_d == S_WB) && (dec_d.cls == CL_LD);
      halted_q       <= (state_d == S_HALT);
    end
  end

  assign bus.imem_req     = imem_req_q;
  assign bus.imem_addr    = pc_q;
  assign bus.dmem_req     = dmem_req_q;
  assign bus.dmem_we      = dmem_we_q;
  assign bus.pc           = pc_q;
  assign bus.ir           = ir_q;
  assign bus.read_addr1   = dec_q.ra1;
  assign bus.read_addr2   = dec_q.ra2;
  assign bus.write_addr   = dec_q.wa;
  assign bus.write_enable = write_enable_q;
  assign bus.alu_op       = dec_q.alu_op;
  assign bus.alu_src_imm  = dec_q.alu_src_imm;
  assign bus.imm          = dec_q.imm;
  assign bus.wb_sel       = wb_sel_q;
  assign bus.halted       = halted_q;
  assign bus.fault        = fault_q;
  assign bus.retired      = retired_q;

endmodule

// File: tb/tb_proc_control_seq.sv
// Testbench for proc_control_seq: directed programs, a memory responder with
// programmable wait states, and a monitor that pops expected fetch addresses
// and writeback controls from queues filled by the stimulus process.
module tb_proc_control_seq;
  import proc_control_seq_pkg::*;

  logic clk;
  logic reset;

  proc_control_seq_if bus ();

  proc_control_seq #(.RESET_PC(16'h0000), .MEM_TIMEOUT(255)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] imem [64];
  int imem_wait = 0;
  int dmem_wait = 0;
  logic [15:0] fetch_q [$];
  logic [8:0]  wb_q [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endfunction

  function automatic logic [8:0] wbv(input logic [2:0] wa, input logic sel,
                                     input logic [3:0] op, input logic src);
    return {wa, sel, op, src};
  endfunction

  // Memory responder: ack after N request cycles (N = wait setting).
  initial begin
    int icnt;
    int dcnt;
    icnt = 0;
    dcnt = 0;
    bus.imem_ack = 1'b0;
    bus.instr    = '0;
    bus.dmem_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.imem_req) begin
        if (icnt >= imem_wait) begin
          bus.imem_ack = 1'b1;
          bus.instr    = imem[bus.imem_addr[5:0]];
          icnt         = 0;
        end else begin
          bus.imem_ack = 1'b0;
          icnt++;
        end
      end else begin
        bus.imem_ack = 1'b0;
        icnt         = 0;
      end
      if (bus.dmem_req) begin
        if (dcnt >= dmem_wait) begin
          bus.dmem_ack = 1'b1;
          dcnt         = 0;
        end else begin
          bus.dmem_ack = 1'b0;
          dcnt++;
        end
      end else begin
        bus.dmem_ack = 1'b0;
        dcnt         = 0;
      end
    end
  end

  // Monitor: every accepted fetch and every writeback pulse is scored.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        if (bus.imem_req && bus.imem_ack) begin
          if (fetch_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL fetch_unexpected: got addr 0x%0h, required no fetch", bus.imem_addr);
          end else begin
            check("fetch_addr", 32'(bus.imem_addr), 32'(fetch_q.pop_front()));
          end
        end
        if (bus.write_enable) begin
          if (wb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL wb_unexpected: got write_addr %0d, required no write", bus.write_addr);
          end else begin
            check("wb_ctrl", 32'(wbv(bus.write_addr, bus.wb_sel, bus.alu_op, bus.alu_src_imm)),
                  32'(wb_q.pop_front()));
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) imem[i] = 16'hF000;
  endtask

  task automatic push_fetch(input int first, input int last);
    for (int a = first; a <= last; a++) fetch_q.push_back(16'(a));
  endtask

  task automatic start();
    reset = 1'b1;
    step();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    check("fetch_q_drained", 32'(fetch_q.size()), 32'd0);
    check("wb_q_drained", 32'(wb_q.size()), 32'd0);
    fetch_q.delete();
    wb_q.delete();
    clear_mem();
    imem_wait    = 0;
    dmem_wait    = 0;
    bus.alu_zero = 1'b0;
  endtask

  task automatic wait_halt(input int budget, input string name);
    int i;
    i = 0;
    while (!bus.halted && i < budget) begin
      step();
      i++;
    end
    check({name, "_halted"}, 32'(bus.halted), 32'd1);
  endtask

  initial begin
    int nreq;
    int nwe;
    int nst;
    int i;
    reset        = 1'b0;
    bus.alu_zero = 1'b0;
    clear_mem();
    step();
    step();
    check("rst_pc", 32'(bus.pc), 32'h0000);
    check("rst_ir", 32'(bus.ir), 32'h0000);
    check("rst_retired", bus.retired, 32'd0);
    check("rst_halted", 32'(bus.halted), 32'd0);
    check("rst_fault", 32'(bus.fault), 32'd0);
    check("rst_strobes", 32'({bus.imem_req, bus.dmem_req, bus.write_enable}), 32'd0);

    // ADDI r1,r0,5; ADDI r2,r0,3; ADD r3,r1,r2; HALT
    imem[0] = 16'h6205;
    imem[1] = 16'h6403;
    imem[2] = 16'h1650;
    push_fetch(0, 3);
    wb_q.push_back(wbv(3'd1, 1'b0, ALU_ADD, 1'b1));
    wb_q.push_back(wbv(3'd2, 1'b0, ALU_ADD, 1'b1));
    wb_q.push_back(wbv(3'd3, 1'b0, ALU_ADD, 1'b0));
    start();
    repeat (12) step();
    check("prog_pc_at_12", 32'(bus.pc), 32'd3);
    check("prog_retired_at_12", bus.retired, 32'd3);
    wait_halt(20, "prog");
    check("prog_final_retired", bus.retired, 32'd4);
    check("prog_final_pc", 32'(bus.pc), 32'd3);
    check("prog_no_fault", 32'(bus.fault), 32'd0);
    do_reset();

    // LD r4,[r1+2] with three dmem wait cycles
    imem[0]   = 16'h7842;
    dmem_wait = 3;
    push_fetch(0, 1);
    wb_q.push_back(wbv(3'd4, 1'b1, ALU_ADD, 1'b1));
    start();
    nreq = 0;
    nwe  = 0;
    nst  = 0;
    for (int c = 0; c < 8; c++) begin
      nreq += int'(bus.dmem_req);
      nwe  += int'(bus.write_enable);
      nst  += int'(bus.dmem_we);
      step();
    end
    check("ld_dmem_req_cycles", 32'(nreq), 32'd4);
    check("ld_we_pulses", 32'(nwe), 32'd1);
    check("ld_dmem_we", 32'(nst), 32'd0);
    check("ld_pc_after_8", 32'(bus.pc), 32'd1);
    check("ld_retired_after_8", bus.retired, 32'd1);
    wait_halt(20, "ld");
    do_reset();

    // BEQ off6=-2 at pc=5: taken once (-> 4), then not taken (-> 6)
    for (int a = 0; a < 5; a++) imem[a] = 16'h0000;
    imem[5]      = 16'h92BE;
    bus.alu_zero = 1'b1;
    push_fetch(0, 5);
    push_fetch(4, 6);
    start();
    i = 0;
    while (!(bus.pc == 16'd4 && bus.retired == 32'd6) && i < 100) begin
      step();
      i++;
    end
    check("beq_taken_pc", 32'(bus.pc), 32'd4);
    bus.alu_zero = 1'b0;
    wait_halt(100, "beq");
    check("beq_final_pc", 32'(bus.pc), 32'd6);
    check("beq_final_retired", bus.retired, 32'd9);
    do_reset();

    // JMP off12=0xFFF at pc=0 loops on itself
    imem[0] = 16'hAFFF;
    push_fetch(0, 0);
    push_fetch(0, 0);
    push_fetch(0, 0);
    start();
    i = 0;
    while (bus.retired != 32'd3 && i < 50) begin
      step();
      i++;
    end
    check("jmp_retired", bus.retired, 32'd3);
    check("jmp_pc", 32'(bus.pc), 32'd0);
    check("jmp_not_halted", 32'(bus.halted), 32'd0);
    do_reset();

    // Fetch never acknowledged -> timeout fault after 255 request cycles
    imem_wait = 1000000;
    start();
    nreq = 0;
    i    = 0;
    while (!bus.halted && i < 400) begin
      nreq += int'(bus.imem_req);
      step();
      i++;
    end
    check("to_req_cycles", 32'(nreq), 32'd255);
    check("to_fault", 32'(bus.fault), 32'd1);
    check("to_halted", 32'(bus.halted), 32'd1);
    check("to_retired", bus.retired, 32'd0);
    check("to_req_dropped", 32'(bus.imem_req), 32'd0);
    reset = 1'b0;
    step();
    check("to_rst_fault", 32'(bus.fault), 32'd0);
    check("to_rst_halted", 32'(bus.halted), 32'd0);
    do_reset();

    // Illegal opcode 0xC
    imem[0] = 16'hC000;
    push_fetch(0, 0);
    start();
    wait_halt(20, "ill");
    check("ill_fault", 32'(bus.fault), 32'd1);
    check("ill_retired", bus.retired, 32'd0);
    check("ill_pc", 32'(bus.pc), 32'd0);
    do_reset();

    // HALT at pc=10 freezes everything
    for (int a = 0; a < 10; a++) imem[a] = 16'h0000;
    push_fetch(0, 10);
    start();
    wait_halt(100, "hlt");
    check("hlt_pc", 32'(bus.pc), 32'd10);
    check("hlt_retired", bus.retired, 32'd11);
    nreq = 0;
    for (int c = 0; c < 5; c++) begin
      nreq += int'(bus.imem_req) + int'(bus.dmem_req) + int'(bus.write_enable);
      step();
    end
    check("hlt_no_activity", 32'(nreq), 32'd0);
    check("hlt_pc_frozen", 32'(bus.pc), 32'd10);
    check("hlt_retired_frozen", bus.retired, 32'd11);
    do_reset();

    // Reset while an LD waits in MEM
    imem[0]   = 16'h7842;
    dmem_wait = 10;
    push_fetch(0, 0);
    start();
    i = 0;
    while (!bus.dmem_req && i < 20) begin
      step();
      i++;
    end
    check("mr_in_mem", 32'(bus.dmem_req), 32'd1);
    step();
    step();
    reset = 1'b0;
    step();
    check("mr_dmem_req", 32'(bus.dmem_req), 32'd0);
    check("mr_pc", 32'(bus.pc), 32'h0000);
    nwe = 0;
    for (int c = 0; c < 3; c++) begin
      nwe += int'(bus.write_enable);
      step();
    end
    check("mr_no_we", 32'(nwe), 32'd0);
    push_fetch(0, 0);
    reset = 1'b1;
    step();
    check("mr_refetch_req", 32'(bus.imem_req), 32'd1);
    check("mr_refetch_addr", 32'(bus.imem_addr), 32'h0000);
    step();
    do_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
